if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, fetch address used after reset.
REQ-002 SHALL have parameter SKID_DEPTH, 2, response skid entries; this is also the limit on outstanding plus buffered words.
REQ-003 SHALL have port clk  in  1  clock; rstb  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_en  in  1  permits new bus requests.
REQ-005 SHALL have ports jmp  in  1  redirect strobe; jmp_addr  in  32  redirect target.
REQ-006 SHALL have ports ibus_req  out  1  fetch request; ibus_addr  out  32  word-aligned address; ibus_gnt  in  1  request accepted.
REQ-007 SHALL have ports ibus_rvalid  in  1  response strobe; ibus_rdata  in  32  response word.
REQ-008 SHALL have ports fifo_wr_en  out  1; fifo_wr_data  out  32; fifo_full  in  1; fifo_jmp  out  1; fifo_jmp_bit1  out  1.
REQ-009 SHALL have port busy  out  1  high when os_cnt!=0 or skid_cnt!=0.

Function
REQ-010 SHALL hold fetch pointer pc[31:2]; ibus_addr={pc,2'b00}.
REQ-011 SHALL implement FSM IDLE/FETCH(/ERR): IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; jmp forces FETCH if fetch_en=1, else IDLE.
REQ-012 SHALL assert ibus_req iff state==FETCH, jmp=0, and os_cnt+skid_cnt<SKID_DEPTH.
REQ-013 SHALL keep ibus_addr stable while ibus_req=1 without ibus_gnt; an ungranted request may be withdrawn only in a jmp or fetch_en=0 cycle.
REQ-014 On ibus_req&ibus_gnt, SHALL increment pc by 1 (30-bit wrap, 0x3FFF_FFFF->0) and increment os_cnt.
REQ-015 On ibus_rvalid, SHALL decrement os_cnt; simultaneous gnt and rvalid SHALL leave os_cnt unchanged.
REQ-016 On ibus_rvalid with drop_cnt!=0, SHALL discard the word and decrement drop_cnt; otherwise SHALL push ibus_rdata into the skid FIFO.
REQ-017 SHALL assert fifo_wr_en = (skid_cnt!=0)&~fifo_full&~jmp with fifo_wr_data = skid head, and pop the head on the same edge.
REQ-018 Response latency: rvalid in cycle N SHALL yield fifo_wr_en no earlier than N+1.
REQ-019 Simultaneous push and pop SHALL keep skid_cnt unchanged; push when full SHALL be impossible by REQ-012.
REQ-020 On jmp, SHALL drive fifo_jmp=1 and fifo_jmp_bit1=jmp_addr[1] combinationally in the same cycle.
REQ-021 On jmp, SHALL load pc=jmp_addr[31:2] and clear the skid FIFO.
REQ-022 On jmp, SHALL set drop_cnt = os_cnt + (ibus_req&ibus_gnt) - ibus_rvalid; a gnt in the jmp cycle counts as stale.
REQ-023 A jmp with os_cnt=0 and no gnt SHALL set drop_cnt=0 and issue the first new request in the next cycle.
REQ-024 Back-to-back jmps SHALL each recompute drop_cnt per REQ-022, with stale responses counted once.

Reset
REQ-025 Reset SHALL set state=IDLE, pc=RESET_PC[31:2], os_cnt=0, drop_cnt=0, skid empty.
REQ-026 During reset, all outputs SHALL be 0 except ibus_addr=RESET_PC; fetch_err=0 and fetch_err_addr=0 when present.
REQ-027 Reset mid-transaction SHALL discard all outstanding tracking; the bus is reset concurrently.

Configuration
REQ-028 Macro IF_FETCH_BUSERR_EN SHALL add ports ibus_err (in, 1, qualifies rvalid), fetch_err (out, 1) and fetch_err_addr (out, 32).
REQ-029 With IF_FETCH_BUSERR_EN defined, a non-dropped rvalid&ibus_err SHALL push nothing, enter ERR, set fetch_err=1 and latch the faulting word address.
REQ-030 With IF_FETCH_BUSERR_EN defined, ERR SHALL issue no requests, still drain the skid FIFO, and exit only on jmp, clearing fetch_err.
REQ-031 Without IF_FETCH_BUSERR_EN, no such ports or ERR state SHALL exist.

Verification
REQ-032 Scenario: reset, RESET_PC=0x100, fetch_en=1, gnt=1, rvalid 1 cycle later -> addrs 0x100,0x104,0x108 in order; fifo_wr_data matches.
REQ-033 Scenario: fifo_full=1 held -> after 2 grants ibus_req=0, skid_cnt=2; releasing full -> 2 writes over 2 cycles, then requests resume.
REQ-034 Scenario: 2 outstanding, jmp to 0x2002 -> fifo_jmp=1, fifo_jmp_bit1=1, next ibus_addr=0x2000; 2 stale responses dropped, never written.
REQ-035 Scenario: jmp in the same cycle as gnt and rvalid with os_cnt=1 -> drop_cnt=1; only post-jmp data reaches the fifo.
REQ-036 Scenario: pc=0xFFFFFFFC granted -> next ibus_addr=0x00000000.
REQ-037 Scenario (IF_FETCH_BUSERR_EN): err on addr 0x40 -> fetch_err=1, fetch_err_addr=0x40, ibus_req=0 until jmp, then fetch_err=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// if_fetch_ctrl - instruction fetch sequencer: bus requests, response skid FIFO, redirect/drop tracking.
// Optional bus-error handling (ERR state, fetch_err ports) via IF_FETCH_BUSERR_EN.   rev 1.0
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          SKID_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        fetch_en,
    input  logic        jmp,
    input  logic [31:0] jmp_addr,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
`ifdef IF_FETCH_BUSERR_EN
    input  logic        ibus_err,
    output logic        fetch_err,
    output logic [31:0] fetch_err_addr,
`endif
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        fifo_jmp,
    output logic        fifo_jmp_bit1,
    output logic        busy
);

    localparam int          CW      = $clog2(SKID_DEPTH + 1);
    localparam int          PW      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(SKID_DEPTH);

`ifdef IF_FETCH_BUSERR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ERR = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
`endif

    state_t        state_q, state_d;
    logic [29:0]   pc_q, pc_d;
    logic [CW-1:0] os_cnt_q, os_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] skid_cnt_q, skid_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   skid_q [SKID_DEPTH];

    logic          w_gnt;
    logic          w_drop;
    logic          w_rsp_err;
    logic          w_push;
    logic          w_unused_jmp0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_gnt  = ibus_req & ibus_gnt;
    assign w_drop = ibus_rvalid & (drop_cnt_q != '0);
`ifdef IF_FETCH_BUSERR_EN
    assign w_rsp_err = ibus_err;
`else
    assign w_rsp_err = 1'b0;
`endif
    // A response arriving with a redirect belongs to the old stream and is discarded.
    assign w_push = ibus_rvalid & ~w_drop & ~w_rsp_err & ~jmp;
    assign w_unused_jmp0 = jmp_addr[0];

    assign ibus_req      = (state_q == FETCH) & ~jmp &
                           (({1'b0, os_cnt_q} + {1'b0, skid_cnt_q}) < DEPTH_C);
    assign ibus_addr     = {pc_q, 2'b00};
    assign fifo_wr_en    = (skid_cnt_q != '0) & ~fifo_full & ~jmp;
    assign fifo_wr_data  = skid_q[rd_ptr_q];
    assign fifo_jmp      = jmp & rstb;
    assign fifo_jmp_bit1 = jmp & jmp_addr[1] & rstb;
    assign busy          = (os_cnt_q != '0) | (skid_cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        os_cnt_d   = os_cnt_q + CW'(w_gnt) - CW'(ibus_rvalid);
        drop_cnt_d = drop_cnt_q;
        skid_cnt_d = skid_cnt_q + CW'(w_push) - CW'(fifo_wr_en);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (w_gnt)      pc_d       = pc_q + 30'd1;
        if (w_drop)     drop_cnt_d = drop_cnt_q - CW'(1);
        if (w_push)     wr_ptr_d   = ptr_inc(wr_ptr_q);
        if (fifo_wr_en) rd_ptr_d   = ptr_inc(rd_ptr_q);

        if (state_q == IDLE && fetch_en)
            state_d = FETCH;
        else if (state_q == FETCH && !fetch_en)
            state_d = IDLE;
`ifdef IF_FETCH_BUSERR_EN
        if (ibus_rvalid & ~w_drop & ibus_err & ~jmp)
            state_d = ERR;
`endif

        // Everything still in flight at a redirect is stale: drop_cnt tracks it
        if (jmp) begin
            state_d    = fetch_en ? FETCH : IDLE;
            pc_d       = jmp_addr[31:2];
            drop_cnt_d = os_cnt_d;
            skid_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC[31:2];
            os_cnt_q   <= '0;
            drop_cnt_q <= '0;
            skid_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < SKID_DEPTH; i++)
                skid_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            os_cnt_q   <= os_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            skid_cnt_q <= skid_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (w_push)
                skid_q[wr_ptr_q] <= ibus_rdata;
        end
    end

`ifdef IF_FETCH_BUSERR_EN
    logic [31:0] fetch_err_addr_q;

    // The erroring word is the oldest live request: pc minus everything still outstanding
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            fetch_err_addr_q <= '0;
        else if (ibus_rvalid & ~w_drop & ibus_err & ~jmp & (state_q != ERR))
            fetch_err_addr_q <= {pc_q - 30'(os_cnt_q), 2'b00};
    end

    assign fetch_err      = (state_q == ERR);
    assign fetch_err_addr = fetch_err_addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// tb_if_fetch_ctrl - randomized bench; a transaction-level model of the fetch stream predicts every output.
module tb_if_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0, rstb = 1'b0;
    logic        fetch_en = 1'b0, jmp = 1'b0, ibus_gnt = 1'b0, ibus_rvalid = 1'b0, fifo_full = 1'b0;
    logic [31:0] jmp_addr = '0, ibus_rdata = '0;
    logic        ibus_req, fifo_wr_en, fifo_jmp, fifo_jmp_bit1, busy;
    logic [31:0] ibus_addr, fifo_wr_data;
`ifdef IF_FETCH_BUSERR_EN
    logic        ibus_err = 1'b0, fetch_err;
    logic [31:0] fetch_err_addr;
    logic        s_ferr;
    logic [31:0] s_ferr_addr;
`endif

    if_fetch_ctrl #(.RESET_PC(RESET_PC), .SKID_DEPTH(DEPTH)) dut (
        .clk(clk), .rstb(rstb), .fetch_en(fetch_en), .jmp(jmp), .jmp_addr(jmp_addr),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
`ifdef IF_FETCH_BUSERR_EN
        .ibus_err(ibus_err), .fetch_err(fetch_err), .fetch_err_addr(fetch_err_addr),
`endif
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .fifo_jmp(fifo_jmp), .fifo_jmp_bit1(fifo_jmp_bit1), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: bus pipeline, live-word stream and fetch pointer
    logic [31:0] pend_addr[$];
    int          pend_rdy[$];
    int          n_stale;
    logic [31:0] live_q[$];
    int          live_skid;
    logic [31:0] exp_pc;
    bit          prev_en;
    bit          in_err;
    logic [31:0] exp_err_addr;
    logic [31:0] err_at = 32'h1;
    int          cyc = 0, lat_min = 1, lat_max = 1;
    logic [31:0] grants[$];
    logic [31:0] writes[$];
    int          n_vec = 0, n_err = 0;
    logic        s_req, s_wr_en, s_jmp, s_bit1, s_busy;
    logic [31:0] s_addr, s_wr_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_5A5A;
    endfunction

    task automatic run_cycle();
        bit          exp_req, exp_wr;
        logic [31:0] raddr;
        int          lat;
        ibus_rvalid = 1'b0;
        ibus_rdata  = '0;
`ifdef IF_FETCH_BUSERR_EN
        ibus_err    = 1'b0;
`endif
        if (pend_addr.size() != 0 && pend_rdy[0] <= cyc) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem_word(pend_addr[0]);
`ifdef IF_FETCH_BUSERR_EN
            ibus_err    = (pend_addr[0] == err_at);
`endif
        end
        @(negedge clk);
        s_req = ibus_req; s_addr = ibus_addr; s_wr_en = fifo_wr_en; s_wr_data = fifo_wr_data;
        s_jmp = fifo_jmp; s_bit1 = fifo_jmp_bit1; s_busy = busy;
        if (s_wr_en === 1'b1) writes.push_back(s_wr_data);
        exp_req = prev_en && !in_err && !jmp && (pend_addr.size() + live_skid < DEPTH);
        exp_wr  = (live_skid != 0) && !fifo_full && !jmp;
        n_vec++; if (s_req !== exp_req) begin n_err++; $display("FAIL ibus_req cyc=%0d got=%b exp=%b", cyc, s_req, exp_req); end
        n_vec++; if (s_addr !== exp_pc) begin n_err++; $display("FAIL ibus_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_pc); end
        n_vec++; if (s_wr_en !== exp_wr) begin n_err++; $display("FAIL fifo_wr_en cyc=%0d got=%b exp=%b", cyc, s_wr_en, exp_wr); end
        if (exp_wr && live_q.size() != 0) begin
            n_vec++; if (s_wr_data !== mem_word(live_q[0])) begin n_err++; $display("FAIL fifo_wr_data cyc=%0d got=%h exp=%h", cyc, s_wr_data, mem_word(live_q[0])); end
        end
        n_vec++; if (s_jmp !== jmp) begin n_err++; $display("FAIL fifo_jmp cyc=%0d got=%b exp=%b", cyc, s_jmp, jmp); end
        n_vec++; if (s_bit1 !== (jmp & jmp_addr[1])) begin n_err++; $display("FAIL fifo_jmp_bit1 cyc=%0d got=%b exp=%b", cyc, s_bit1, jmp & jmp_addr[1]); end
        n_vec++; if (s_busy !== (pend_addr.size() != 0 || live_skid != 0)) begin n_err++; $display("FAIL busy cyc=%0d got=%b", cyc, s_busy); end
`ifdef IF_FETCH_BUSERR_EN
        s_ferr = fetch_err; s_ferr_addr = fetch_err_addr;
        n_vec++; if (s_ferr !== in_err) begin n_err++; $display("FAIL fetch_err cyc=%0d got=%b exp=%b", cyc, s_ferr, in_err); end
        n_vec++; if (s_ferr_addr !== exp_err_addr) begin n_err++; $display("FAIL fetch_err_addr cyc=%0d got=%h exp=%h", cyc, s_ferr_addr, exp_err_addr); end
`endif
        @(posedge clk);
        if (ibus_rvalid) begin
            raddr = pend_addr.pop_front();
            void'(pend_rdy.pop_front());
            if (n_stale > 0) n_stale--;
            else if (!jmp) begin
`ifdef IF_FETCH_BUSERR_EN
                if (ibus_err) begin
                    if (!in_err) exp_err_addr = raddr;
                    in_err = 1'b1;
                    live_q.delete(live_skid);
                end else live_skid++;
`else
                live_skid++;
`endif
            end
        end
        if (exp_wr) begin void'(live_q.pop_front()); live_skid--; end
        if (exp_req && ibus_gnt) begin
            grants.push_back(exp_pc);
            lat = $urandom_range(lat_max, lat_min);
            pend_addr.push_back(exp_pc);
            pend_rdy.push_back(cyc + lat);
            live_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (jmp) begin
            n_stale = pend_addr.size();
            live_q.delete();
            live_skid = 0;
            exp_pc = jmp_addr & 32'hFFFF_FFFC;
            in_err = 1'b0;
        end
        prev_en = fetch_en;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0; fetch_en = 1'b0; jmp = 1'b0; ibus_gnt = 1'b0; fifo_full = 1'b0;
        ibus_rvalid = 1'b0; ibus_rdata = '0;
        repeat (2) @(posedge clk);
        pend_addr.delete(); pend_rdy.delete(); n_stale = 0; live_q.delete(); live_skid = 0;
        exp_pc = RESET_PC; prev_en = 1'b0; in_err = 1'b0; exp_err_addr = '0;
        grants.delete(); writes.delete();
        #1 rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; fetch_en = 1'b1; jmp = 1'b1; jmp_addr = 32'hFFFF_FFFE; ibus_gnt = 1'b1; ibus_rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if (ibus_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", ibus_req); end
        n_vec++; if (ibus_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr got=%h exp=%h", ibus_addr, RESET_PC); end
        n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got=%b exp=0", fifo_wr_en); end
        n_vec++; if (fifo_wr_data !== 32'h0) begin n_err++; $display("FAIL rst_wr_data got=%h exp=0", fifo_wr_data); end
        n_vec++; if ({fifo_jmp, fifo_jmp_bit1} !== 2'b00) begin n_err++; $display("FAIL rst_jmp got=%b exp=00", {fifo_jmp, fifo_jmp_bit1}); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
`ifdef IF_FETCH_BUSERR_EN
        n_vec++; if ({fetch_err, fetch_err_addr} !== 33'h0) begin n_err++; $display("FAIL rst_err got=%b/%h exp=0", fetch_err, fetch_err_addr); end
`endif
        do_reset();
    endtask

    task automatic test_seq();
        logic [31:0] g;
        do_reset();
        lat_min = 1; lat_max = 1; fetch_en = 1'b1; ibus_gnt = 1'b1;
        repeat (12) run_cycle();
        for (int i = 0; i < 3; i++) begin
            g = (i < grants.size()) ? grants[i] : 32'hDEAD_BEEF;
            n_vec++; if (g !== RESET_PC + 32'(4 * i)) begin n_err++; $display("FAIL seq_addr%0d got=%h exp=%h", i, g, RESET_PC + 32'(4 * i)); end
            g = (i < writes.size()) ? writes[i] : 32'hDEAD_BEEF;
            n_vec++; if (g !== mem_word(RESET_PC + 32'(4 * i))) begin n_err++; $display("FAIL seq_data%0d got=%h exp=%h", i, g, mem_word(RESET_PC + 32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1; fifo_full = 1'b1; fetch_en = 1'b1; ibus_gnt = 1'b1;
        repeat (8) run_cycle();
        n_vec++; if (grants.size() != 2 || s_req !== 1'b0 || s_busy !== 1'b1 || writes.size() != 0) begin
            n_err++; $display("FAIL bp_hold got grants=%0d req=%b busy=%b writes=%0d exp 2/0/1/0", grants.size(), s_req, s_busy, writes.size()); end
        fifo_full = 1'b0;
        run_cycle();
        n_vec++; if ({s_wr_en, s_req} !== 2'b10) begin n_err++; $display("FAIL bp_rel1 got wr/req=%b exp=10", {s_wr_en, s_req}); end
        run_cycle();
        n_vec++; if ({s_wr_en, s_req} !== 2'b11) begin n_err++; $display("FAIL bp_rel2 got wr/req=%b exp=11", {s_wr_en, s_req}); end
        repeat (6) run_cycle();
    endtask

    task automatic test_jmp();
        int stale_w;
        do_reset();
        lat_min = 5; lat_max = 5; fetch_en = 1'b1; ibus_gnt = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() < 2; i++) run_cycle();
        n_vec++; if (pend_addr.size() != 2) begin n_err++; $display("FAIL jmp_setup got pending=%0d exp=2", pend_addr.size()); end
        jmp = 1'b1; jmp_addr = 32'h0000_2002;
        run_cycle();
        jmp = 1'b0;
        n_vec++; if ({s_jmp, s_bit1} !== 2'b11) begin n_err++; $display("FAIL jmp_flags got=%b exp=11", {s_jmp, s_bit1}); end
        run_cycle();
        n_vec++; if (s_addr !== 32'h0000_2000) begin n_err++; $display("FAIL jmp_target got=%h exp=00002000", s_addr); end
        repeat (14) run_cycle();
        stale_w = 0;
        foreach (writes[i]) if (writes[i] == mem_word(RESET_PC) || writes[i] == mem_word(RESET_PC + 32'd4)) stale_w++;
        n_vec++; if (stale_w != 0 || writes.size() == 0 || writes[0] !== mem_word(32'h2000)) begin
            n_err++; $display("FAIL jmp_drop got stale_writes=%0d writes=%0d exp 0 stale, first=%h", stale_w, writes.size(), mem_word(32'h2000)); end
    endtask

    task automatic test_jmp_rvalid();
        bit hit;
        do_reset();
        lat_min = 3; lat_max = 3; fetch_en = 1'b1; ibus_gnt = 1'b1;
        for (int i = 0; i < 6 && grants.size() == 0; i++) run_cycle();
        ibus_gnt = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            if (pend_addr.size() == 1 && pend_rdy[0] <= cyc) begin
                jmp = 1'b1; jmp_addr = 32'h0000_3000; ibus_gnt = 1'b1; hit = 1'b1;
            end
            run_cycle();
            jmp = 1'b0;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL jr_setup got=no_rvalid_cycle exp=rvalid_with_jmp"); end
        repeat (10) run_cycle();
        n_vec++; if (writes.size() == 0 || writes[0] !== mem_word(32'h3000)) begin
            n_err++; $display("FAIL jr_first got writes=%0d exp first=%h", writes.size(), mem_word(32'h3000)); end
    endtask

    task automatic test_wrap();
        logic [31:0] g0, g1;
        do_reset();
        lat_min = 1; lat_max = 2; fetch_en = 1'b1; ibus_gnt = 1'b1;
        jmp = 1'b1; jmp_addr = 32'hFFFF_FFFC;
        run_cycle();
        jmp = 1'b0;
        repeat (6) run_cycle();
        g0 = (grants.size() > 0) ? grants[0] : 32'hDEAD_BEEF;
        g1 = (grants.size() > 1) ? grants[1] : 32'hDEAD_BEEF;
        n_vec++; if (g0 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first got=%h exp=fffffffc", g0); end
        n_vec++; if (g1 !== 32'h0) begin n_err++; $display("FAIL wrap_next got=%h exp=00000000", g1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] g0;
        do_reset();
        lat_min = 3; lat_max = 3; fetch_en = 1'b1; ibus_gnt = 1'b1;
        repeat (5) run_cycle();
        do_reset();
        run_cycle();
        fetch_en = 1'b1; ibus_gnt = 1'b1;
        repeat (4) run_cycle();
        g0 = (grants.size() > 0) ? grants[0] : 32'hDEAD_BEEF;
        n_vec++; if (g0 !== RESET_PC) begin n_err++; $display("FAIL midrst_first got=%h exp=%h", g0, RESET_PC); end
    endtask

`ifdef IF_FETCH_BUSERR_EN
    task automatic test_err();
        int reqs;
        do_reset();
        err_at = 32'h40; lat_min = 1; lat_max = 1; fetch_en = 1'b1; ibus_gnt = 1'b1;
        jmp = 1'b1; jmp_addr = 32'h40;
        run_cycle();
        jmp = 1'b0;
        repeat (3) run_cycle();
        n_vec++; if ({s_ferr, s_ferr_addr} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL err_set got=%b/%h exp=1/00000040", s_ferr, s_ferr_addr); end
        reqs = 0;
        repeat (5) begin run_cycle(); if (s_req) reqs++; end
        n_vec++; if (reqs != 0) begin n_err++; $display("FAIL err_noreq got=%0d exp=0", reqs); end
        jmp = 1'b1; jmp_addr = 32'h80;
        run_cycle();
        jmp = 1'b0;
        run_cycle();
        n_vec++; if (s_ferr !== 1'b0) begin n_err++; $display("FAIL err_clear got=%b exp=0", s_ferr); end
        repeat (4) run_cycle();
        err_at = 32'h1;
    endtask
`endif

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4;
`ifdef IF_FETCH_BUSERR_EN
        err_at = 32'h40;
`endif
        for (int i = 0; i < 3000; i++) begin
            fetch_en  = ($urandom_range(0, 9) != 0);
            ibus_gnt  = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            jmp       = ($urandom_range(0, 22) == 0);
            jmp_addr  = $urandom & 32'h0000_00FF;
            run_cycle();
        end
        jmp = 1'b0; fetch_en = 1'b0; fifo_full = 1'b0;
        repeat (10) run_cycle();
        err_at = 32'h1;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_backpressure();
        test_jmp();
        test_jmp_rvalid();
        test_wrap();
        test_reset_mid();
`ifdef IF_FETCH_BUSERR_EN
        test_err();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
